// File: rtl/s3_chien_forney.sv
// RS(255,251) Chien search + Forney: streams one error value per symbol (pos 254..0), err_sop at kes_done+2, cf_done at +257.
// No backpressure: one shadow result is buffered during a scan, further arrivals are dropped and flagged in cf_ovf.
module s3_chien_forney (
    input  logic       clk,
    input  logic       rstn,
    input  logic       kes_done,
    input  logic [7:0] rs_lambda0,
    input  logic [7:0] rs_lambda1,
    input  logic [7:0] rs_lambda2,
    input  logic [7:0] rs_omega0,
    input  logic [7:0] rs_omega1,
    output logic [7:0] err_val,
    output logic       err_valid,
    output logic       err_sop,
    output logic       err_eop,
    output logic       cf_done,
    output logic [1:0] err_cnt,
    output logic       dec_fail,
    output logic       cf_ovf
);

    typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

    localparam logic [7:0] ALPHA     = 8'h02;
    localparam logic [7:0] ALPHA_SQ  = 8'h04;
    localparam logic [7:0] ALPHA_INV = 8'h8E;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] sh;
        prod = 8'h00;
        sh   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) prod = prod ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
        end
        return prod;
    endfunction

    // a^254 = a^-1 for a != 0, and naturally 0 for a == 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    state_t     state, state_nxt;

    logic [7:0] l0, inv_l1, t1, t2, w0, w1, x;
    logic [7:0] pos;
    logic [1:0] roots;
    logic [1:0] deg;

    logic       buf_full;
    logic [7:0] buf_l0, buf_l1, buf_l2, buf_o0, buf_o1;

    logic       fin_exit;
    logic       load_dir;
    logic       load_buf;
    logic       load;
    logic [7:0] src_l0, src_l1, src_l2, src_o0, src_o1;
    logic [1:0] src_deg;

    logic [7:0] lval;
    logic [7:0] wval;
    logic [7:0] fval;
    logic       fail_now;

    assign fin_exit = (state == FIN) && cf_done;
    assign load_dir = (state == IDLE) && kes_done && !buf_full;
    assign load_buf = buf_full && ((state == IDLE) || fin_exit);
    assign load     = load_dir || load_buf;

    assign src_l0 = load_buf ? buf_l0 : rs_lambda0;
    assign src_l1 = load_buf ? buf_l1 : rs_lambda1;
    assign src_l2 = load_buf ? buf_l2 : rs_lambda2;
    assign src_o0 = load_buf ? buf_o0 : rs_omega0;
    assign src_o1 = load_buf ? buf_o1 : rs_omega1;

    assign src_deg = (src_l2 != 8'h00) ? 2'd2 :
                     (src_l1 != 8'h00) ? 2'd1 : 2'd0;

    assign lval = l0 ^ t1 ^ t2;
    assign wval = w0 ^ w1;
    assign fval = gf_mul(gf_mul(x, wval), inv_l1);

    // inv_l1 is zero exactly when lambda1 was zero
    assign fail_now = (roots != deg) || (l0 == 8'h00) ||
                      ((deg != 2'd0) && (inv_l1 == 8'h00));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load) state_nxt = SCAN;
            SCAN: if (pos == 8'd0) state_nxt = FIN;
            FIN:  if (fin_exit) state_nxt = buf_full ? SCAN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Working registers and root counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            l0     <= 8'h00;
            inv_l1 <= 8'h00;
            t1     <= 8'h00;
            t2     <= 8'h00;
            w0     <= 8'h00;
            w1     <= 8'h00;
            x      <= 8'h00;
            pos    <= 8'd0;
            roots  <= 2'd0;
            deg    <= 2'd0;
        end else if (load) begin
            l0     <= src_l0;
            inv_l1 <= gf_inv(src_l1);
            t1     <= gf_mul(src_l1, ALPHA);
            t2     <= gf_mul(src_l2, ALPHA_SQ);
            w0     <= src_o0;
            w1     <= gf_mul(src_o1, ALPHA);
            x      <= ALPHA_INV;
            pos    <= 8'd254;
            roots  <= 2'd0;
            deg    <= src_deg;
        end else if (state == SCAN) begin
            t1  <= gf_mul(t1, ALPHA);
            t2  <= gf_mul(t2, ALPHA_SQ);
            w1  <= gf_mul(w1, ALPHA);
            x   <= gf_mul(x, ALPHA_INV);
            pos <= pos - 8'd1;
            if ((lval == 8'h00) && (roots != 2'd3)) roots <= roots + 2'd1;
        end
    end

    // Shadow buffer: a result that arrives while busy waits here
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_full <= 1'b0;
            buf_l0   <= 8'h00;
            buf_l1   <= 8'h00;
            buf_l2   <= 8'h00;
            buf_o0   <= 8'h00;
            buf_o1   <= 8'h00;
            cf_ovf   <= 1'b0;
        end else begin
            if (kes_done && !load_dir) begin
                if (buf_full && !load_buf) begin
                    cf_ovf <= 1'b1;
                end else begin
                    buf_full <= 1'b1;
                    buf_l0   <= rs_lambda0;
                    buf_l1   <= rs_lambda1;
                    buf_l2   <= rs_lambda2;
                    buf_o0   <= rs_omega0;
                    buf_o1   <= rs_omega1;
                end
            end else if (load_buf) begin
                buf_full <= 1'b0;
            end
        end
    end

    // Registered output stream and end-of-codeword status
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_val   <= 8'h00;
            err_valid <= 1'b0;
            err_sop   <= 1'b0;
            err_eop   <= 1'b0;
            cf_done   <= 1'b0;
            err_cnt   <= 2'd0;
            dec_fail  <= 1'b0;
        end else begin
            err_valid <= (state == SCAN);
            err_sop   <= (state == SCAN) && (pos == 8'd254);
            err_eop   <= (state == SCAN) && (pos == 8'd0);
            err_val   <= ((state == SCAN) && (lval == 8'h00)) ? fval : 8'h00;
            cf_done   <= (state == FIN) && !cf_done;
            if ((state == FIN) && !cf_done) begin
                err_cnt  <= roots;
                dec_fail <= fail_now;
            end
        end
    end

endmodule

// File: tb/tb_s3_chien_forney.sv
// Directed bench for s3_chien_forney; every streamed value is compared with a log/antilog GF(2^8) model.
module tb_s3_chien_forney;

    logic       clk;
    logic       rstn;
    logic       kes_done;
    logic [7:0] rs_lambda0, rs_lambda1, rs_lambda2, rs_omega0, rs_omega1;
    logic [7:0] err_val;
    logic       err_valid, err_sop, err_eop, cf_done;
    logic [1:0] err_cnt;
    logic       dec_fail, cf_ovf;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int gexp [0:254];
    int glog [0:255];

    s3_chien_forney dut (
        .clk        (clk),
        .rstn       (rstn),
        .kes_done   (kes_done),
        .rs_lambda0 (rs_lambda0),
        .rs_lambda1 (rs_lambda1),
        .rs_lambda2 (rs_lambda2),
        .rs_omega0  (rs_omega0),
        .rs_omega1  (rs_omega1),
        .err_val    (err_val),
        .err_valid  (err_valid),
        .err_sop    (err_sop),
        .err_eop    (err_eop),
        .cf_done    (cf_done),
        .err_cnt    (err_cnt),
        .dec_fail   (dec_fail),
        .cf_ovf     (cf_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    function automatic int ginv(input int a);
        if (a == 0) return 0;
        return gexp[(255 - glog[a]) % 255];
    endfunction

    // Error value at position p: X*Omega(X^-1)/Lambda'(X^-1) with X = alpha^p
    function automatic logic [7:0] model_val(input int l0, input int l1, input int l2,
                                             input int o0, input int o1, input int p);
        int xi, lv, wv;
        xi = gexp[(255 - p) % 255];
        lv = l0 ^ gmul(l1, xi) ^ gmul(l2, gmul(xi, xi));
        wv = o0 ^ gmul(o1, xi);
        if (lv != 0) return 8'h00;
        return 8'(gmul(gmul(gexp[p], wv), ginv(l1)));
    endfunction

    task automatic drive(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                         input logic [7:0] b0, input logic [7:0] b1, output int t);
        @(posedge clk); #1;
        kes_done   = 1'b1;
        rs_lambda0 = a0;
        rs_lambda1 = a1;
        rs_lambda2 = a2;
        rs_omega0  = b0;
        rs_omega1  = b1;
        t = cyc;
        @(posedge clk); #1;
        kes_done = 1'b0;
    endtask

    // Waits for err_sop, checks all 255 positions, then cf_done and status; returns one cycle after cf_done
    task automatic check_stream(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                                input logic [7:0] b0, input logic [7:0] b1, input int exp_sop,
                                input logic [1:0] exp_cnt, input logic exp_fail, output int cf_cyc);
        int guard;
        guard = 0;
        while (err_valid !== 1'b1 && guard < 600) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("sop_cycle", cyc, exp_sop);
        for (int p = 254; p >= 0; p--) begin
            chk("valid", err_valid, 1);
            chk("val", err_val, model_val(a0, a1, a2, b0, b1, p));
            chk("sop", err_sop, (p == 254));
            chk("eop", err_eop, (p == 0));
            chk("done_early", cf_done, 0);
            @(posedge clk); #1;
        end
        cf_cyc = cyc;
        chk("done", cf_done, 1);
        chk("done_cycle", cf_cyc, exp_sop + 255);
        chk("valid_after", err_valid, 0);
        chk("val_after", err_val, 0);
        chk("err_cnt", err_cnt, exp_cnt);
        chk("dec_fail", dec_fail, exp_fail);
        @(posedge clk); #1;
        chk("done_pulse", cf_done, 0);
        chk("err_cnt_hold", err_cnt, exp_cnt);
        chk("dec_fail_hold", dec_fail, exp_fail);
    endtask

    initial begin
        int t, t2, cf1, cf2, seen;
        int v;

        v = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = v;
            glog[v] = i;
            v = v << 1;
            if (v & 256) v = v ^ 285;
        end
        glog[0] = 0;

        rstn = 1'b0;
        kes_done = 1'b0;
        rs_lambda0 = 8'h00; rs_lambda1 = 8'h00; rs_lambda2 = 8'h00;
        rs_omega0 = 8'h00;  rs_omega1 = 8'h00;
        #12;
        chk("rst_valid", err_valid, 0);
        chk("rst_val", err_val, 0);
        chk("rst_done", cf_done, 0);
        chk("rst_cnt", err_cnt, 0);
        chk("rst_fail", dec_fail, 0);
        chk("rst_ovf", cf_ovf, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // zero errors
        drive(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, t);
        check_stream(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, t + 2, 2'd0, 1'b0, cf1);

        // single error at position 10, value 5A
        drive(8'h01, 8'h74, 8'h00, 8'h5A, 8'h00, t);
        check_stream(8'h01, 8'h74, 8'h00, 8'h5A, 8'h00, t + 2, 2'd1, 1'b0, cf1);

        // same locator scaled by alpha gives the same stream
        drive(8'h02, 8'hE8, 8'h00, 8'hB4, 8'h00, t);
        check_stream(8'h01, 8'h74, 8'h00, 8'h5A, 8'h00, t + 2, 2'd1, 1'b0, cf1);

        // double root at x=1: one Chien hit, degree 2, lambda1 zero
        drive(8'h01, 8'h00, 8'h01, 8'h00, 8'h00, t);
        check_stream(8'h01, 8'h00, 8'h01, 8'h00, 8'h00, t + 2, 2'd1, 1'b1, cf1);

        // lambda0 zero: no roots
        drive(8'h00, 8'h74, 8'h00, 8'h5A, 8'h00, t);
        check_stream(8'h00, 8'h74, 8'h00, 8'h5A, 8'h00, t + 2, 2'd0, 1'b1, cf1);

        // two errors at positions 3 and 7
        drive(8'h01, 8'h88, 8'h74, 8'h11, 8'h22, t);
        check_stream(8'h01, 8'h88, 8'h74, 8'h11, 8'h22, t + 2, 2'd2, 1'b0, cf1);
        chk("ovf_clear", cf_ovf, 0);

        // back-to-back: second result buffered, third dropped
        drive(8'h01, 8'h74, 8'h00, 8'h5A, 8'h00, t);
        fork
            begin
                repeat (3) @(posedge clk);
                drive(8'h01, 8'h88, 8'h74, 8'h11, 8'h22, t2);
                repeat (4) @(posedge clk);
                drive(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, t2);
            end
        join_none
        check_stream(8'h01, 8'h74, 8'h00, 8'h5A, 8'h00, t + 2, 2'd1, 1'b0, cf1);
        chk("ovf_set", cf_ovf, 1);
        check_stream(8'h01, 8'h88, 8'h74, 8'h11, 8'h22, cf1 + 2, 2'd2, 1'b0, cf2);
        chk("b2b_gap", cf2 - cf1, 257);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (err_valid === 1'b1 || cf_done === 1'b1) seen++;
            @(posedge clk); #1;
        end
        chk("dropped_quiet", seen, 0);
        chk("ovf_sticky", cf_ovf, 1);

        // reset in the middle of a scan
        drive(8'h01, 8'h74, 8'h00, 8'h5A, 8'h00, t);
        repeat (155) @(posedge clk);
        #1;
        chk("pre_rst_valid", err_valid, 1);
        chk("pre_rst_cycle", cyc, t + 156);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", err_valid, 0);
        chk("mid_rst_val", err_val, 0);
        chk("mid_rst_sop", err_sop, 0);
        chk("mid_rst_eop", err_eop, 0);
        chk("mid_rst_done", cf_done, 0);
        chk("mid_rst_cnt", err_cnt, 0);
        chk("mid_rst_fail", dec_fail, 0);
        chk("mid_rst_ovf", cf_ovf, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (err_valid === 1'b1 || cf_done === 1'b1) seen++;
        end
        chk("post_rst_quiet", seen, 0);
        drive(8'h01, 8'h74, 8'h00, 8'h5A, 8'h00, t);
        check_stream(8'h01, 8'h74, 8'h00, 8'h5A, 8'h00, t + 2, 2'd1, 1'b0, cf1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
